// File: rtl/ifd_pkg.sv
// Shared definitions for the instruction fetch/decode block: opcode map,
// ALU and jump-control encodings, the decoded field bundle and FSM states.
package ifd_pkg;

    // Opcodes carried in instruction bits [15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    // Everything from here upwards is unassigned
    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'hC;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    // Jump-control encoding
    localparam logic [1:0] JCTL_NONE = 2'b00;
    localparam logic [1:0] JCTL_JMP  = 2'b01;
    localparam logic [1:0] JCTL_JZ   = 2'b10;
    localparam logic [1:0] JCTL_JNZ  = 2'b11;

    // Fetch/decode sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_HALT    = 3'd4
    } ifd_state_e;

    // Decoded instruction fields as presented to the instruction register
    typedef struct packed {
        logic [3:0] c_addr;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic [7:0] immediate_val;
        logic [7:0] addr;
        logic [2:0] alu_control;
        logic [1:0] jctl;
        logic       im_sel;
        logic       reg_write;
        logic       data_read;
        logic       data_write;
        logic       reg_addr;
    } ifd_fields_t;

    // True for opcodes with no assigned meaning
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= OP_FIRST_ILLEGAL);
    endfunction

endpackage

// File: rtl/ifd_decoder.sv
// Combinational decoder: 16-bit instruction word -> decoded field bundle.
// Fields an opcode does not use are driven to zero. Unassigned opcodes
// decode exactly like NOP; trapping on them is the caller's business.
module ifd_decoder
    import ifd_pkg::*;
(
    input  logic [15:0]  instr_i,
    output ifd_fields_t  fields_o
);

    logic [3:0] op;
    assign op = instr_i[15:12];

    // Map the opcode to its field set; everything else stays zero
    always_comb begin
        fields_o = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                fields_o.c_addr      = instr_i[11:8];
                fields_o.a_addr      = instr_i[7:4];
                fields_o.b_addr      = instr_i[3:0];
                // ALU ops are numbered consecutively from ADD
                fields_o.alu_control = op[2:0] - 3'd1;
                fields_o.reg_write   = 1'b1;
            end
            OP_ADDI: begin
                fields_o.c_addr        = instr_i[11:8];
                fields_o.immediate_val = instr_i[7:0];
                fields_o.alu_control   = ALU_ADD;
                fields_o.im_sel        = 1'b1;
                fields_o.reg_write     = 1'b1;
            end
            OP_LD: begin
                fields_o.c_addr    = instr_i[11:8];
                fields_o.addr      = instr_i[7:0];
                fields_o.data_read = 1'b1;
                fields_o.reg_write = 1'b1;
                fields_o.reg_addr  = 1'b1;
            end
            OP_ST: begin
                // The [11:8] field names the register whose value is stored
                fields_o.c_addr     = instr_i[11:8];
                fields_o.addr       = instr_i[7:0];
                fields_o.data_write = 1'b1;
            end
            OP_JMP: begin
                fields_o.addr = instr_i[7:0];
                fields_o.jctl = JCTL_JMP;
            end
            OP_JZ: begin
                fields_o.addr = instr_i[7:0];
                fields_o.jctl = JCTL_JZ;
            end
            OP_JNZ: begin
                fields_o.addr = instr_i[7:0];
                fields_o.jctl = JCTL_JNZ;
            end
            default: begin
                fields_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch_decode.sv
// Instruction fetch/decode front end. Fetches words over req/ack, decodes
// them, presents the fields over valid/ready and steers the PC (including
// conditional jumps resolved against the ALU zero flag).
// All outputs come straight from rising-edge flops so a falling-edge
// consumer sees them settled half a cycle early.
// Build option IFD_ILLEGAL_TRAP_EN: an unassigned opcode sets the sticky
// illegal flag and parks the sequencer in HALT until reset; without it such
// words are presented as NOP.
module instruction_fetch_decode
    import ifd_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  a_addr,
    output logic [3:0]  b_addr,
    output logic [3:0]  c_addr,
    output logic [7:0]  immediate_val,
    output logic [7:0]  addr,
    output logic [2:0]  alu_control,
    output logic [1:0]  JCTL,
    output logic        im_sel,
    output logic        reg_write,
    output logic        data_read,
    output logic        data_write,
    output logic        reg_addr,
    input  logic        flag_valid,
    input  logic        zero_flag,
    output logic [7:0]  pc,
    output logic        illegal
);

    ifd_state_e  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    ifd_fields_t fields_q, fields_d;
    ifd_fields_t dec_fields;
    logic        req_q;
    logic        valid_q;
    logic [7:0]  pc_inc;
    ifd_state_e  after_state;
    logic        taken;
`ifdef IFD_ILLEGAL_TRAP_EN
    logic        illegal_q, illegal_d;
`endif

    ifd_decoder u_decoder (
        .instr_i  (imem_data),
        .fields_o (dec_fields)
    );

    assign pc_inc      = pc_q + 8'd1;
    // Where to go once the current instruction has fully retired
    assign after_state = enable ? ST_FETCH : ST_IDLE;
    assign taken       = (fields_q.jctl == JCTL_JZ) ? zero_flag : ~zero_flag;

    // Next-state, next-PC and field capture for the fetch/present sequencer
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fields_d = fields_q;
`ifdef IFD_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A started fetch always completes, even if enable drops
                if (imem_ack) begin
                    fields_d = dec_fields;
                    state_d  = ST_PRESENT;
`ifdef IFD_ILLEGAL_TRAP_EN
                    if (is_illegal_op(imem_data[15:12])) begin
                        fields_d  = fields_q;
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
`endif
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    unique case (fields_q.jctl)
                        JCTL_JMP: begin
                            pc_d    = fields_q.addr;
                            state_d = after_state;
                        end
                        JCTL_JZ, JCTL_JNZ: begin
                            state_d = ST_RESOLVE;
                        end
                        default: begin
                            pc_d    = pc_inc;
                            state_d = after_state;
                        end
                    endcase
                end
            end
            ST_RESOLVE: begin
                if (flag_valid) begin
                    pc_d    = taken ? fields_q.addr : pc_inc;
                    state_d = after_state;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC, field and handshake-output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            fields_q <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fields_q <= fields_d;
            // Handshake strobes are registered copies of the next state
            req_q    <= (state_d == ST_FETCH);
            valid_q  <= (state_d == ST_PRESENT);
        end
    end

`ifdef IFD_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign out_valid     = valid_q;
    assign c_addr        = fields_q.c_addr;
    assign a_addr        = fields_q.a_addr;
    assign b_addr        = fields_q.b_addr;
    assign immediate_val = fields_q.immediate_val;
    assign addr          = fields_q.addr;
    assign alu_control   = fields_q.alu_control;
    assign JCTL          = fields_q.jctl;
    assign im_sel        = fields_q.im_sel;
    assign reg_write     = fields_q.reg_write;
    assign data_read     = fields_q.data_read;
    assign data_write    = fields_q.data_write;
    assign reg_addr      = fields_q.reg_addr;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Self-checking bench for instruction_fetch_decode: a directed table of
// instructions with hand-computed fields, randomized instructions checked
// against a spec-level decode/PC model, and hand sequences for enable drop,
// asynchronous reset during PRESENT and illegal opcodes.
module tb_instruction_fetch_decode;

    logic        CLK;
    logic        RST_N;
    logic        enable;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic [7:0]  immediate_val, addr;
    logic [2:0]  alu_control;
    logic [1:0]  JCTL;
    logic        im_sel, reg_write, data_read, data_write, reg_addr;
    logic        flag_valid, zero_flag;
    logic [7:0]  pc;
    logic        illegal;

    int n_vec = 0;
    int n_mis = 0;
    int model_pc = 0;

    typedef struct {
        logic [15:0] w;
        int          ready_dly;
        int          flag_dly;
        bit          zf;
        logic [3:0]  c, a, b;
        logic [7:0]  imm, ad;
        logic [2:0]  alu;
        logic [1:0]  jc;
        logic        ims, rw, dr, dw, ra;
    } vec_t;

    vec_t tbl[14];

    instruction_fetch_decode #(.RESET_PC(8'h00)) dut (
        .CLK(CLK), .RST_N(RST_N), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
        .immediate_val(immediate_val), .addr(addr),
        .alu_control(alu_control), .JCTL(JCTL),
        .im_sel(im_sel), .reg_write(reg_write), .data_read(data_read),
        .data_write(data_write), .reg_addr(reg_addr),
        .flag_valid(flag_valid), .zero_flag(zero_flag),
        .pc(pc), .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish required finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (pc model %0h)", name, act, exp, model_pc[7:0]);
        end
    endtask

    function automatic logic [63:0] dut_fields();
        return {19'd0, c_addr, a_addr, b_addr, immediate_val, addr, alu_control, JCTL,
                im_sel, reg_write, data_read, data_write, reg_addr};
    endfunction

    function automatic logic [63:0] exp_fields(input vec_t v);
        return {19'd0, v.c, v.a, v.b, v.imm, v.ad, v.alu, v.jc, v.ims, v.rw, v.dr, v.dw, v.ra};
    endfunction

    // Reference decode straight from the instruction-set description
    function automatic vec_t ref_decode(input logic [15:0] w);
        vec_t v;
        int op;
        bit is_alu, is_addi, is_ld, is_st, is_jump;
        op      = int'(w[15:12]);
        is_alu  = (op >= 1) && (op <= 5);
        is_addi = (op == 6);
        is_ld   = (op == 7);
        is_st   = (op == 8);
        is_jump = (op >= 9) && (op <= 11);
        v = '{default: 0};
        v.w   = w;
        v.c   = (is_alu || is_addi || is_ld || is_st) ? w[11:8] : 4'h0;
        v.a   = is_alu ? w[7:4] : 4'h0;
        v.b   = is_alu ? w[3:0] : 4'h0;
        v.imm = is_addi ? w[7:0] : 8'h00;
        v.ad  = (is_ld || is_st || is_jump) ? w[7:0] : 8'h00;
        v.alu = is_alu ? 3'(op - 1) : 3'd0;
        v.jc  = is_jump ? 2'(op - 8) : 2'd0;
        v.ims = is_addi;
        v.rw  = is_alu || is_addi || is_ld;
        v.dr  = is_ld;
        v.dw  = is_st;
        v.ra  = is_ld;
        return v;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_vec++;
            n_mis++;
            $display("FAIL req_timeout: imem_req got 0 required 1");
        end
    endtask

    // One full instruction: fetch, present (with stall), optional resolve
    task automatic run_instr(input vec_t e, input int ack_dly, input bit drop_en);
        bit ok;
        bit tk;
        wait_req(ok);
        if (!ok) return;
        chk("fetch_addr", imem_addr, model_pc);
        chk("pc_out", pc, model_pc);
        for (int k = 0; k < ack_dly; k++) begin
            imem_ack   = 1'b0;
            flag_valid = 1'($urandom);
            tick();
            chk("req_held", imem_req, 1);
            chk("no_valid_in_fetch", out_valid, 0);
        end
        flag_valid = 1'b0;
        if (drop_en) enable = 1'b0;
        imem_ack  = 1'b1;
        imem_data = e.w;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        chk("valid_after_ack", out_valid, 1);
        chk("req_drop", imem_req, 0);
        chk("c_addr", c_addr, e.c);
        chk("a_addr", a_addr, e.a);
        chk("b_addr", b_addr, e.b);
        chk("imm", immediate_val, e.imm);
        chk("addr", addr, e.ad);
        chk("alu", alu_control, e.alu);
        chk("jctl", JCTL, e.jc);
        chk("strobes", {im_sel, reg_write, data_read, data_write, reg_addr},
            {e.ims, e.rw, e.dr, e.dw, e.ra});
        for (int k = 0; k < e.ready_dly; k++) begin
            out_ready = 1'b0;
            imem_ack  = 1'($urandom);
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_no_req", imem_req, 0);
            chk("stall_fields", dut_fields(), exp_fields(e));
        end
        imem_ack  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_clear", out_valid, 0);
        if (e.jc == 2'd2 || e.jc == 2'd3) begin
            for (int k = 0; k < e.flag_dly; k++) begin
                flag_valid = 1'b0;
                zero_flag  = 1'($urandom);
                tick();
                chk("resolve_wait", imem_req, 0);
            end
            flag_valid = 1'b1;
            zero_flag  = e.zf;
            tick();
            flag_valid = 1'b0;
        end
        case (e.jc)
            2'd1:    tk = 1'b1;
            2'd2:    tk = e.zf;
            2'd3:    tk = !e.zf;
            default: tk = 1'b0;
        endcase
        model_pc = tk ? int'(e.ad) : (model_pc + 1) % 256;
        if (enable) begin
            chk("next_req", imem_req, 1);
            chk("next_addr", imem_addr, model_pc);
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk("idle_no_req", imem_req, 0);
                chk("idle_pc", pc, model_pc);
                tick();
            end
            enable = 1'b1;
        end
        $display("instr %h pc->%02h", e.w, model_pc[7:0]);
    endtask

    initial begin
        vec_t v;
        bit ok;
        //            w      rdy flg zf  c     a     b     imm    ad     alu   jc    ims rw dr dw ra
        tbl[0]  = '{16'h1312, 0, 0, 0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h00, 3'd0, 2'd0, 0, 1, 0, 0, 0};
        tbl[1]  = '{16'h6A7F, 5, 0, 0, 4'hA, 4'h0, 4'h0, 8'h7F, 8'h00, 3'd0, 2'd0, 1, 1, 0, 0, 0};
        tbl[2]  = '{16'h2345, 1, 0, 0, 4'h3, 4'h4, 4'h5, 8'h00, 8'h00, 3'd1, 2'd0, 0, 1, 0, 0, 0};
        tbl[3]  = '{16'h5ABC, 0, 0, 0, 4'hA, 4'hB, 4'hC, 8'h00, 8'h00, 3'd4, 2'd0, 0, 1, 0, 0, 0};
        tbl[4]  = '{16'h7C33, 2, 0, 0, 4'hC, 4'h0, 4'h0, 8'h00, 8'h33, 3'd0, 2'd0, 0, 1, 1, 0, 1};
        tbl[5]  = '{16'h8D44, 0, 0, 0, 4'hD, 4'h0, 4'h0, 8'h00, 8'h44, 3'd0, 2'd0, 0, 0, 0, 1, 0};
        tbl[6]  = '{16'hA020, 0, 4, 1, 4'h0, 4'h0, 4'h0, 8'h00, 8'h20, 3'd0, 2'd2, 0, 0, 0, 0, 0};
        tbl[7]  = '{16'hB0FE, 0, 1, 1, 4'h0, 4'h0, 4'h0, 8'h00, 8'hFE, 3'd0, 2'd3, 0, 0, 0, 0, 0};
        tbl[8]  = '{16'hB0FE, 1, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'hFE, 3'd0, 2'd3, 0, 0, 0, 0, 0};
        tbl[9]  = '{16'hA020, 0, 2, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h20, 3'd0, 2'd2, 0, 0, 0, 0, 0};
        tbl[10] = '{16'h0FFF, 0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 3'd0, 2'd0, 0, 0, 0, 0, 0};
        tbl[11] = '{16'h90FF, 0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'hFF, 3'd0, 2'd1, 0, 0, 0, 0, 0};
        tbl[12] = '{16'h9040, 0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h40, 3'd0, 2'd1, 0, 0, 0, 0, 0};
        tbl[13] = '{16'h0000, 0, 0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 3'd0, 2'd0, 0, 0, 0, 0, 0};

        RST_N = 1'b0; enable = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
        out_ready = 1'b0; flag_valid = 1'b0; zero_flag = 1'b0;
        #3;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_fields", dut_fields(), 64'd0);
        chk("rst_illegal", illegal, 0);
        #9 RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_disabled", imem_req, 0);
        end

        // Directed table, including pc wrap and jump at 8'hFF
        enable = 1'b1;
        model_pc = 0;
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i], 1, 1'b0);
        end

        // enable dropped during fetch: instruction completes, then idle
        v = ref_decode(16'h1456);
        v.ready_dly = 2;
        run_instr(v, 1, 1'b1);
        v = ref_decode(16'hA077);
        v.flag_dly = 1; v.zf = 1'b1;
        run_instr(v, 0, 1'b1);

        // Randomized instructions against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
`ifdef IFD_ILLEGAL_TRAP_EN
            w[15:12] = 4'($urandom_range(0, 11));
`endif
            v = ref_decode(w);
            v.ready_dly = $urandom_range(0, 3);
            v.flag_dly  = $urandom_range(0, 3);
            v.zf        = 1'($urandom);
            run_instr(v, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset while presenting
        wait_req(ok);
        if (ok) begin
            imem_ack = 1'b1; imem_data = 16'h1312;
            tick();
            imem_ack = 1'b0;
            chk("pre_rst_valid", out_valid, 1);
            #2 RST_N = 1'b0;
            #1;
            chk("async_rst_valid", out_valid, 0);
            chk("async_rst_pc", pc, 8'h00);
            chk("async_rst_fields", dut_fields(), 64'd0);
            #2 RST_N = 1'b1;
            model_pc = 0;
            tick();
            run_instr(tbl[0], 0, 1'b0);
        end

        // Illegal opcode
`ifdef IFD_ILLEGAL_TRAP_EN
        wait_req(ok);
        if (ok) begin
            imem_ack = 1'b1; imem_data = 16'hF000;
            tick();
            imem_ack = 1'b0;
            for (int k = 0; k < 6; k++) begin
                chk("halt_no_valid", out_valid, 0);
                chk("halt_no_req", imem_req, 0);
                chk("halt_illegal", illegal, 1);
                out_ready = 1'b1;
                tick();
            end
            out_ready = 1'b0;
            #2 RST_N = 1'b0;
            #1;
            chk("halt_rst_illegal", illegal, 0);
            chk("halt_rst_pc", pc, 8'h00);
            #2 RST_N = 1'b1;
            model_pc = 0;
            tick();
            run_instr(tbl[3], 0, 1'b0);
        end
`else
        run_instr(ref_decode(16'hF000), 1, 1'b0);
        chk("illegal_stays_0", illegal, 0);
        run_instr(ref_decode(16'hC123), 0, 1'b0);
        chk("illegal_stays_0b", illegal, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
